// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core: multi-cycle RV32I core with one shared valid/ready memory bus for fetch,
// load and store. ECALL/EBREAK halt the core; illegal opcodes and misaligned accesses trap it.
module rv_multicycle_core #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned INSTRET_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [31:0]          bus_addr,
  output logic [3:0]           bus_be,
  output logic [31:0]          bus_wdata,
  input  logic                 bus_ready,
  input  logic [31:0]          bus_rdata,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted,
  output logic                 trap,
  output logic [2:0]           dbg_state
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
    OP_IMM = 7'b0010011, OP_REG = 7'b0110011, OP_FENCE = 7'b0001111;

  state_t               state_q, state_d;
  logic [31:0]          pc_q, ir_q, rs1_q, rs2_q, res_q, tgt_q, ea_q;
  logic                 taken_q, run_q, halted_q, trap_q;
  logic [INSTRET_W-1:0] instret_q;
  logic [31:0]          rf [32];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic        is_ld, is_st, is_jal, is_jalr, is_br, is_reg, is_env, legal, wr_en;
  logic [31:0] imm, op_b, alu, ea, tgt, exec_res, lane, ld_data, st_wdata;
  logic        cond, take, misaligned, mem_phase, xfer_done;
  logic [3:0]  st_be;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign f3      = ir_q[14:12];
  assign f7      = ir_q[31:25];
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);
  assign is_br   = (opcode == OP_BR);
  assign is_reg  = (opcode == OP_REG);
  assign is_env  = (ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073);
  assign wr_en   = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_REG};

  // Immediate generation and RV32I legality (funct3/funct7 must name a real instruction).
  always_comb begin
    imm   = {{20{ir_q[31]}}, ir_q[31:20]};
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin imm = {ir_q[31:12], 12'b0}; legal = 1'b1; end
      OP_JAL: begin
        imm   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
        legal = 1'b1;
      end
      OP_JALR: legal = (f3 == 3'b000);
      OP_BR: begin
        imm   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        legal = (f3[2:1] != 2'b01);
      end
      OP_LD: legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
      OP_ST: begin
        imm   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
      end
      OP_IMM: legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                      (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      OP_REG: legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      OP_FENCE: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    op_b = is_reg ? rs2_q : imm;
    case (f3)
      3'b000:  alu = (is_reg && f7[5]) ? rs1_q - op_b : rs1_q + op_b;
      3'b001:  alu = rs1_q << op_b[4:0];
      3'b010:  alu = {31'b0, $signed(rs1_q) < $signed(op_b)};
      3'b011:  alu = {31'b0, rs1_q < op_b};
      3'b100:  alu = rs1_q ^ op_b;
      3'b101:  alu = f7[5] ? 32'($signed(rs1_q) >>> op_b[4:0]) : rs1_q >> op_b[4:0];
      3'b110:  alu = rs1_q | op_b;
      default: alu = rs1_q & op_b;
    endcase
    case (f3)
      3'b000:  cond = (rs1_q == rs2_q);
      3'b001:  cond = (rs1_q != rs2_q);
      3'b100:  cond = $signed(rs1_q) < $signed(rs2_q);
      3'b101:  cond = $signed(rs1_q) >= $signed(rs2_q);
      3'b110:  cond = rs1_q < rs2_q;
      3'b111:  cond = rs1_q >= rs2_q;
      default: cond = 1'b0;
    endcase
    ea         = rs1_q + imm;
    tgt        = is_jalr ? (ea & ~32'd1) : pc_q + imm;
    take       = is_jal || is_jalr || (is_br && cond);
    misaligned = ((is_ld || is_st) &&
                  ((f3[1:0] == 2'b01 && ea[0]) || (f3[1:0] == 2'b10 && ea[1:0] != 2'b00))) ||
                 (take && tgt[1:0] != 2'b00);
    case (opcode)
      OP_LUI:          exec_res = imm;
      OP_AUIPC:        exec_res = pc_q + imm;
      OP_JAL, OP_JALR: exec_res = pc_q + 32'd4;
      default:         exec_res = alu;
    endcase
  end

  always_comb begin
    lane = bus_rdata >> {ea_q[1:0], 3'b000};
    case (f3)
      3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_data = {24'b0, lane[7:0]};
      3'b101:  ld_data = {16'b0, lane[15:0]};
      default: ld_data = lane;
    endcase
    case (f3[1:0])
      2'b00:   begin st_be = 4'b0001 << ea_q[1:0]; st_wdata = {4{rs2_q[7:0]}}; end
      2'b01:   begin st_be = ea_q[1] ? 4'b1100 : 4'b0011; st_wdata = {2{rs2_q[15:0]}}; end
      default: begin st_be = 4'b1111; st_wdata = rs2_q; end
    endcase
  end

  // Handshake: bus_req is high for the whole of FETCH/MEM with addr/we/be/wdata held constant;
  // the transfer completes on the first rising edge with bus_req && bus_ready, after which the
  // FSM leaves the state so bus_req drops. run_q keeps the bus idle until reset is released.
  assign mem_phase = (state_q == S_MEM);
  assign bus_req   = run_q && (state_q == S_FETCH || mem_phase);
  assign bus_we    = bus_req && mem_phase && is_st;
  assign bus_addr  = !bus_req ? 32'd0 : mem_phase ? {ea_q[31:2], 2'b00} : pc_q;
  assign bus_be    = !bus_req ? 4'd0 : bus_we ? st_be : 4'b1111;
  assign bus_wdata = bus_we ? st_wdata : 32'd0;
  assign xfer_done = bus_req && bus_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (xfer_done) state_d = S_DECODE;
      S_DECODE: state_d = (is_env || !legal) ? S_HALT : S_EXEC;
      S_EXEC:   state_d = misaligned ? S_HALT : (is_ld || is_st) ? S_MEM : S_WB;
      S_MEM:    if (xfer_done) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_VECTOR;
      run_q     <= 1'b0;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
      instret_q <= '0;
      ir_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      res_q     <= '0;
      tgt_q     <= '0;
      ea_q      <= '0;
      taken_q   <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      case (state_q)
        S_FETCH: if (xfer_done) ir_q <= bus_rdata;
        S_DECODE: begin
          rs1_q <= rf[ir_q[19:15]];
          rs2_q <= rf[ir_q[24:20]];
          if (is_env) halted_q <= 1'b1;
          else if (!legal) trap_q <= 1'b1;
        end
        S_EXEC: begin
          res_q   <= exec_res;
          tgt_q   <= tgt;
          taken_q <= take;
          ea_q    <= ea;
          if (misaligned) trap_q <= 1'b1;
        end
        S_MEM: if (xfer_done && is_ld) res_q <= ld_data;
        S_WB: begin
          if (wr_en && rd != 5'd0) rf[rd] <= res_q;
          pc_q      <= taken_q ? tgt_q : pc_q + 32'd4;
          instret_q <= instret_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign retire    = (state_q == S_WB);
  assign instret   = instret_q;
  assign halted    = halted_q;
  assign trap      = trap_q;
  assign dbg_state = state_q;
endmodule

// File: doc/rv_multicycle_core.md
# rv_multicycle_core

Multi-cycle RV32I core that replaces the single-cycle datapath's combinational instruction and data memories with one shared, variable-latency memory bus using a valid/ready handshake. A state machine sequences each instruction through fetch, decode, execute, memory and write-back. It adds precise halting on ECALL/EBREAK, a trap on illegal or misaligned accesses, and a retired-instruction counter. It is the CPU top for SoC builds whose memories cannot answer in zero cycles.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset; must be word aligned.
- INSTRET_W, 32, width of the retired-instruction counter (8..64).
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- bus_req  out  1  transfer request; address and data are stable while high.
- bus_we  out  1  1 = store, 0 = fetch or load.
- bus_addr  out  32  byte address, always word aligned (addr[1:0] = 0).
- bus_be  out  4  byte enables; 4'b1111 for fetch and load.
- bus_wdata  out  32  store data, byte-lane replicated.
- bus_ready  in  1  transfer completes in the cycle bus_req && bus_ready.
- bus_rdata  in  32  read data, valid only in the completing cycle.
- retire  out  1  one-cycle pulse per retired instruction.
- instret  out  INSTRET_W  count of retired instructions.
- halted  out  1  set by ECALL/EBREAK; held until reset.
- trap  out  1  set by illegal opcode or misaligned access; held until reset.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH
  - Drive bus_req=1, bus_we=0, bus_addr=pc.
  - On completion, latch IR and go to DECODE.
- DECODE
  - Read rs1 and rs2 from the 32x32 register file; generate the immediate.
  - An opcode not in RV32I sets trap and goes to HALT.
  - ECALL/EBREAK set halted and go to HALT.
  - FENCE executes as a NOP.
- EXEC: ALU result, branch compare, and target computation.
  - JAL target = pc+imm.
  - JALR target = (rs1+imm) & ~1.
  - Branch target = pc+imm.
  - Load/store effective address = rs1+imm.
  - Misaligned accesses (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) set trap and go to HALT. No bus request is issued for them.
  - Jump or taken branch with target[1:0]!=0 sets trap and goes to HALT.
- MEM (loads and stores only)
  - One bus transfer with bus_addr = {ea[31:2],2'b00}.
  - SB: be = 1<<ea[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 or 4'b1100, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111.
  - Loads select the addressed lane, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- WB
  - Write rd unless rd = x0. x0 always reads 0.
  - Write-back source per class:
    - ALU and LUI: result.
    - AUIPC: pc+imm.
    - JAL/JALR: pc+4.
    - Loads: extended data.
  - pc ← target for a jump or taken branch, otherwise pc+4.
  - Pulse retire; instret += 1, wrapping modulo 2^INSTRET_W. Then go to FETCH.
- HALT: absorbing; no bus requests, no register or pc writes.
- Trapping or halting instructions do not retire. They leave the pc pointing at the offending instruction.

## Timing
- Reset (rst_n sampled low)
  - State = FETCH, pc = RESET_VECTOR, x1..x31 = 0.
  - bus_req = bus_we = 0, bus_be = 0, bus_addr = 0, bus_wdata = 0.
  - retire = 0, instret = 0, halted = trap = 0.
- First bus_req is issued in the first cycle after rst_n is sampled high.
- Reset has priority over everything. Asserting it during an open transfer drops bus_req in the next cycle. A bus_ready that coincides with the reset edge is ignored.
- Handshake
  - bus_req stays high with unchanged addr/we/be/wdata until the completing cycle. It is deasserted the cycle after, and next re-asserted in a later state; there are no back-to-back transfers without an intervening state.
  - bus_ready while bus_req=0 is ignored.
- Cycle counts with W wait states per transfer (W=0: ready in the first request cycle):
  - ALU, branch, jump, LUI, AUIPC, FENCE: 4+W cycles.
  - Loads and stores: 5+2W cycles.
- Register-file write and instret update take effect at the WB clock edge.
- retire is high during the WB cycle only.

## Test plan
- Reset vector and fetch
  - Stimulus: RESET_VECTOR=0x100, zero-wait memory.
  - Response: first fetch bus_addr=0x100.
- ALU program
  - Stimulus: addi x1,x0,5; addi x2,x1,-7.
  - Response: x2 = 0xFFFFFFFE; retire pulses every 4 cycles; instret=2.
- Wait states
  - Stimulus: bus_ready delayed 3 cycles on every transfer.
  - Response: addi retires every 7 cycles; an lw retires in 11 cycles; bus_addr is stable throughout each request.
- Byte store and load
  - Stimulus: sb of 0x80 to 0x103, then lb and lbu from 0x103.
  - Response: be=4'b1000, wdata=0x80808080; lb → 0xFFFFFF80; lbu → 0x00000080.
- Control flow
  - Stimulus: beq taken (offset +8), beq not taken, jalr to 0x201.
  - Response: pc = pc+8; pc = pc+4; jump lands at 0x200 with rd = pc+4; writes to x0 are discarded.
- Faults and reset
  - Misaligned lw at 0x102: trap=1, no MEM request, instret unchanged.
  - ecall: halted=1 and stays 1.
  - rst_n low mid-fetch: bus_req=0 next cycle, then refetch from RESET_VECTOR.
